// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin arbiter that lets one of N_REQ producers at a time
// push a burst of words into a shared FIFO.
//
// Ports
//   clk                    clock, all state changes on the rising edge
//   rst_n                  synchronous active-low reset
//   req_valid[N_REQ]       per-producer word valid
//   req_data[N_REQ*DW]     producer i data at [i*DW +: DW]
//   req_last[N_REQ]        marks the final word of a producer burst
//   req_ready[N_REQ]       per-producer accept (combinational)
//   fifo_push              FIFO push strobe (combinational, one per transfer)
//   fifo_data_in[DW]       FIFO write data (combinational, 0 when idle)
//   fifo_full              FIFO full flag, stalls the current burst
//   fifo_push_err_on_full  FIFO overflow error flag
//   grant_id               current or most recently granted producer
//   busy                   a grant is held
//   err_clr                clears err_sticky
//   err_sticky             latched FIFO overflow error
module fifo_push_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DW-1:0]        req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       fifo_push,
    output logic [DW-1:0]              fifo_data_in,
    input  logic                       fifo_full,
    input  logic                       fifo_push_err_on_full,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       err_sticky
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   rr_nx;
    logic [GW-1:0]   grant_nx;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   cnt_nx;
    logic            err_nx;

    logic            active;
    logic            xfer;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   grant_after;
    logic            burst_done;

    // Burst is live only outside reset so a word offered during reset is never taken.
    assign active = rst_n && (state == BURST);
    assign xfer   = active && req_valid[grant_id] && !fifo_full;

    // Round robin: first requester at or above rr_ptr, otherwise the lowest one below it.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!pick_found && (GW'(j) >= rr_ptr) && req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(j);
            end
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!pick_found && req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(j);
            end
        end
    end

    // Pointer value that follows the current grant, wrapping for any N_REQ.
    assign grant_after = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // A transfer ends the burst when it carries last or reaches the burst limit.
    assign burst_done = req_last[grant_id] || (burst_cnt == CW'(MAX_BURST - 1));

    // Datapath outputs: steer the granted producer onto the FIFO port.
    always_comb begin
        req_ready    = '0;
        fifo_data_in = '0;
        fifo_push    = xfer;
        busy         = active;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (GW'(i) == grant_id) begin
                req_ready[i] = active && !fifo_full;
                if (active) begin
                    fifo_data_in = req_data[i*DW +: DW];
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        cnt_nx   = burst_cnt;
        err_nx   = err_sticky;

        if (fifo_push_err_on_full) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx = BURST;
                    grant_nx = pick_idx;
                    cnt_nx   = '0;
                end
            end
            BURST: begin
                if (xfer) begin
                    cnt_nx = burst_cnt + 1'b1;
                    if (burst_done) begin
                        state_nx = IDLE;
                        rr_nx    = grant_after;
                    end
                end else if (!req_valid[grant_id] && !fifo_full) begin
                    // Producer abandoned the burst; a full stall keeps the grant.
                    state_nx = IDLE;
                    rr_nx    = grant_after;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nx;
            grant_id   <= grant_nx;
            rr_ptr     <= rr_nx;
            burst_cnt  <= cnt_nx;
            err_sticky <= err_nx;
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Bench for fifo_push_arb: directed scenarios plus randomized traffic, all
// compared against a transaction-level reference of the arbitration rules.
module tb_fifo_push_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int GW = $clog2(N);

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              fifo_push;
    logic [DW-1:0]     fifo_data_in;
    logic              fifo_full;
    logic              fifo_push_err_on_full;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              err_clr;
    logic              err_sticky;

    fifo_push_arb #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid             (req_valid),
        .req_data              (req_data),
        .req_last              (req_last),
        .req_ready             (req_ready),
        .fifo_push             (fifo_push),
        .fifo_data_in          (fifo_data_in),
        .fifo_full             (fifo_full),
        .fifo_push_err_on_full (fifo_push_err_on_full),
        .grant_id              (grant_id),
        .busy                  (busy),
        .err_clr               (err_clr),
        .err_sticky            (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: holder of the grant (or none), words taken, pointer, sticky error.
    bit m_busy = 1'b0;
    int m_gid  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    bit m_err  = 1'b0;
    bit m_xfer = 1'b0;
    int cyc    = 0;

    int             push_gids[$];
    logic [DW-1:0]  push_data[$];
    int             push_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] x, input int i);
        logic [N-1:0] s;
        s = x >> i;
        return s[0];
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (bit_of(v, (ptr + k) % N)) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // One clock: drive at negedge, check just after, advance the reference at posedge.
    task automatic drive(input logic r, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic [N-1:0] l, input logic f, input logic eo, input logic ec);
        logic [N-1:0]  e_ready;
        logic [DW-1:0] e_data;
        logic          e_active;
        int            p;
        @(negedge clk);
        rst_n = r; req_valid = v; req_data = d; req_last = l; fifo_full = f;
        fifo_push_err_on_full = eo; err_clr = ec;
        #1;
        e_active = r && m_busy;
        m_xfer   = e_active && bit_of(v, m_gid) && !f;
        e_ready  = (e_active && !f) ? (N'(1) << m_gid) : '0;
        e_data   = e_active ? DW'(d >> (m_gid * DW)) : '0;
        chk("busy",       32'(busy),         32'(e_active));
        chk("fifo_push",  32'(fifo_push),    32'(m_xfer));
        chk("req_ready",  32'(req_ready),    32'(e_ready));
        chk("fifo_data",  32'(fifo_data_in), 32'(e_data));
        chk("grant_id",   32'(grant_id),     32'(m_gid));
        chk("err_sticky", 32'(err_sticky),   32'(m_err));
        if (fifo_push === 1'b1) begin
            push_gids.push_back(int'(grant_id));
            push_data.push_back(fifo_data_in);
            push_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (!r) begin
            m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            if (eo)      m_err = 1'b1;
            else if (ec) m_err = 1'b0;
            if (!m_busy) begin
                p = pick(v, m_ptr);
                if (p >= 0) begin
                    m_busy = 1'b1; m_gid = p; m_cnt = 0;
                end
            end else if (m_xfer) begin
                m_cnt++;
                if (bit_of(l, m_gid) || m_cnt == MB) begin
                    m_busy = 1'b0; m_ptr = (m_gid + 1) % N;
                end
            end else if (!bit_of(v, m_gid) && !f) begin
                m_busy = 1'b0; m_ptr = (m_gid + 1) % N;
            end
        end
    endtask

    task automatic clear_log();
        push_gids.delete();
        push_data.delete();
        push_cyc.delete();
    endtask

    task automatic do_reset();
        drive(1'b0, '0, rand_data(), '0, 1'b0, 1'b0, 1'b0);
        clear_log();
    endtask

    int exp034[5] = '{0, 1, 2, 3, 0};
    int words;
    int sent;
    int xgid;
    logic [N-1:0] v;
    logic [N*DW-1:0] d;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        fifo_full = 1'b0; fifo_push_err_on_full = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset cycle and the first cycle after it, with producers already requesting.
        drive(1'b0, '1, rand_data(), '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, '1, rand_data(), '0, 1'b0, 1'b0, 1'b0);

        // All requesters valid, single-word bursts: strict rotation.
        do_reset();
        repeat (10) drive(1'b1, '1, rand_data(), '1, 1'b0, 1'b0, 1'b0);
        chk("s034_pushes", 32'(push_gids.size()), 32'd5);
        for (int k = 0; k < 5 && k < push_gids.size(); k++)
            chk("s034_order", 32'(push_gids[k]), 32'(exp034[k]));

        // Producer 2 alone, 6 words, no last: split by the burst limit.
        do_reset();
        words = 6;
        repeat (16) begin
            drive(1'b1, (words > 0) ? N'(4) : '0, rand_data(), '0, 1'b0, 1'b0, 1'b0);
            if (m_xfer) words--;
        end
        chk("s035_pushes", 32'(push_gids.size()), 32'd6);
        foreach (push_gids[k]) chk("s035_gid", 32'(push_gids[k]), 32'd2);
        if (push_cyc.size() >= 5) chk("s035_gap", 32'(push_cyc[4] - push_cyc[3]), 32'd2);

        // FIFO full for three cycles mid-burst; no word may be lost.
        do_reset();
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            d = '0;
            d[DW-1:0] = DW'(32'hA0 + 32'(sent));
            drive(1'b1, (sent < 4) ? N'(1) : '0, d, (sent == 3) ? N'(1) : '0,
                  (c >= 3 && c < 6), 1'b0, 1'b0);
            if (m_xfer) sent++;
        end
        chk("s036_pushes", 32'(push_data.size()), 32'd4);
        for (int k = 0; k < 4 && k < push_data.size(); k++)
            chk("s036_data", 32'(push_data[k]), 32'hA0 + 32'(k));

        // Producer 1 abandons after two words; producer 2 is next.
        do_reset();
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            v = N'(4);
            if (sent < 2) v[1] = 1'b1;
            xgid = m_gid;
            drive(1'b1, v, rand_data(), N'(4), 1'b0, 1'b0, 1'b0);
            if (m_xfer && xgid == 1) sent++;
        end
        chk("s037_pushes", 32'(push_gids.size()), 32'd3);
        if (push_gids.size() >= 3) begin
            chk("s037_g0", 32'(push_gids[0]), 32'd1);
            chk("s037_g1", 32'(push_gids[1]), 32'd1);
            chk("s037_g2", 32'(push_gids[2]), 32'd2);
        end

        // Error set beats clear in the same cycle; a later clear alone wins.
        drive(1'b1, '0, rand_data(), '0, 1'b0, 1'b1, 1'b1);
        #1 chk("s038_set", 32'(err_sticky), 32'd1);
        drive(1'b1, '0, rand_data(), '0, 1'b0, 1'b0, 1'b1);
        #1 chk("s038_clr", 32'(err_sticky), 32'd0);

        // Reset during the second word of a burst.
        do_reset();
        drive(1'b1, N'(8), rand_data(), '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, N'(8), rand_data(), '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, N'(8), rand_data(), '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("s039_busy", 32'(busy), 32'd0);
        chk("s039_gid",  32'(grant_id), 32'd0);
        chk("s039_pushes", 32'(push_gids.size()), 32'd1);
        clear_log();
        drive(1'b1, '1, rand_data(), '1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, '1, rand_data(), '1, 1'b0, 1'b0, 1'b0);
        chk("s039_ptr", 32'(push_gids.size() == 1 ? push_gids[0] : -1), 32'd0);

        // Randomized traffic with occasional resets, stalls and error pulses.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(63) != 0),
                  N'($urandom) | N'($urandom),
                  rand_data(),
                  N'($urandom) & N'($urandom),
                  ($urandom_range(3) == 0),
                  ($urandom_range(19) == 0),
                  ($urandom_range(9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of producers (2..8).
REQ-002 Parameter DW, default 8, SHALL set the data width.
REQ-003 Parameter MAX_BURST, default 4, SHALL set the maximum words per grant (1..16).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  SHALL be the per-producer word-valid signal.
REQ-007 req_data  in  N_REQ*DW  SHALL carry producer data; producer i occupies bits [i*DW +: DW].
REQ-008 req_last  in  N_REQ  SHALL mark the final word of a producer burst.
REQ-009 req_ready  out  N_REQ  SHALL be the per-producer accept signal.
REQ-010 fifo_push  out  1  SHALL drive the FIFO push input.
REQ-011 fifo_data_in  out  DW  SHALL drive the FIFO data input.
REQ-012 fifo_full  in  1  SHALL be the FIFO full flag.
REQ-013 fifo_push_err_on_full  in  1  SHALL be the FIFO overflow error flag.
REQ-014 grant_id  out  clog2(N_REQ)  SHALL be the index of the current or last granted producer.
REQ-015 busy  out  1  SHALL be high while a grant is held.
REQ-016 err_clr  in  1  SHALL clear err_sticky.
REQ-017 err_sticky  out  1  SHALL be the latched overflow error.

Function
REQ-018 The FSM SHALL have two states, IDLE and BURST; busy SHALL equal (state==BURST).
REQ-019 In IDLE with any req_valid set, the FSM SHALL select the first requester at or after rr_ptr (wrap modulo N_REQ), register it into grant_id, and enter BURST next cycle.
REQ-020 In IDLE, req_ready SHALL be all zero and fifo_push SHALL be 0.
REQ-021 In BURST, req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-022 A transfer SHALL occur in a BURST cycle when req_valid[grant_id] && !fifo_full; fifo_push SHALL be 1 exactly in transfer cycles (combinational).
REQ-023 fifo_data_in SHALL equal req_data slice grant_id in BURST and hold 0 in IDLE.
REQ-024 fifo_push SHALL never assert while fifo_full is 1.
REQ-025 A burst counter SHALL reset to 0 on grant and increment on each transfer.
REQ-026 BURST SHALL exit to IDLE after a transfer with req_last[grant_id]=1, or after the MAX_BURST-th transfer, whichever comes first.
REQ-027 BURST SHALL exit to IDLE when req_valid[grant_id] is 0 and fifo_full is 0 (producer abandon); a fifo_full stall SHALL NOT cause exit.
REQ-028 On every BURST exit, rr_ptr SHALL become (grant_id+1) mod N_REQ; grant_id SHALL hold its value through IDLE.
REQ-029 Minimum latency SHALL be one cycle from req_valid in IDLE to the first fifo_push; IDLE SHALL last at least one cycle between grants.
REQ-030 err_sticky SHALL set on any cycle with fifo_push_err_on_full=1 and clear on err_clr=1; set SHALL win when both occur in the same cycle.

Reset
REQ-031 When rst_n=0 at posedge clk: state=IDLE, rr_ptr=0, grant_id=0, burst count=0, err_sticky=0.
REQ-032 During reset, and in the first cycle after it, req_ready, fifo_push and busy SHALL be 0 and fifo_data_in SHALL be 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further push; a word presented in that cycle SHALL NOT be accepted.

Verification
REQ-034 All four requesters valid with req_last on every word -> grant order 0,1,2,3,0, one fifo_push per grant.
REQ-035 Producer 2 alone sends 6 words, no req_last, MAX_BURST=4 -> 4 pushes, IDLE for 1 cycle, re-grant to 2, 2 pushes.
REQ-036 fifo_full=1 for 3 cycles mid-burst -> fifo_push=0 and req_ready=0 for those 3 cycles, busy stays 1, burst resumes with no data lost.
REQ-037 Producer 1 drops req_valid after 2 words -> exit to IDLE; rr_ptr=2; producer 2 granted next if valid.
REQ-038 fifo_push_err_on_full pulse with err_clr=1 in the same cycle -> err_sticky=1; a later err_clr alone -> 0.
REQ-039 rst_n=0 during the 2nd word of a burst -> next cycle busy=0, grant_id=0, rr_ptr=0, no push.
